// File: rtl/temporal_pkg.sv
// rtl/temporal_pkg.sv - shared types and defaults for temporal-coded encoders/decoders
package temporal_pkg;

    localparam int GAMMA_CYCLE_WIDTH_DEFAULT = 16;
    localparam int TW_DEFAULT = $clog2(GAMMA_CYCLE_WIDTH_DEFAULT);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ON,
        HIGH,
        DONE
    } pw_state_t;

    typedef struct packed {
        logic [TW_DEFAULT-1:0] onset;
        logic [TW_DEFAULT-1:0] width;
        logic                  no_spike;
        logic                  truncated;
        logic                  multi;
    } pw_result_t;

endpackage

// File: rtl/temporal_pw_decoder_if.sv
// rtl/temporal_pw_decoder_if.sv - valid/ready result bus of the pulse-width decoder
interface temporal_pw_decoder_if
    import temporal_pkg::*;
#(
    parameter int TW = TW_DEFAULT
) ();

    logic          out_valid;
    logic          out_ready;
    logic [TW-1:0] out_onset;
    logic [TW-1:0] out_width;
    logic          out_no_spike;
    logic          out_truncated;
    logic          out_multi;

    modport master (
        output out_valid, out_onset, out_width, out_no_spike, out_truncated, out_multi,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_onset, out_width, out_no_spike, out_truncated, out_multi,
        output out_ready
    );

endinterface

// File: rtl/temporal_result_reg.sv
// rtl/temporal_result_reg.sv - one-entry valid/ready holding register with sticky overrun
module temporal_result_reg #(
    parameter int W = 8
) (
    input  logic         aclk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         overrun
);

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            overrun   <= 1'b0;
        end else if (load) begin
            // A full register that is not being drained keeps its result; the new one is lost.
            if (!out_valid || out_ready) begin
                out_data  <= load_data;
                out_valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/temporal_pw_decoder.sv
// rtl/temporal_pw_decoder.sv - measures onset and width of the first pulse in each gamma cycle
module temporal_pw_decoder
    import temporal_pkg::*;
#(
    parameter int GAMMA_CYCLE_WIDTH = GAMMA_CYCLE_WIDTH_DEFAULT,
    parameter int TW = $clog2(GAMMA_CYCLE_WIDTH)
) (
    input  logic                  aclk,
    input  logic                  grst_n,
    input  logic                  gamma_start,
    input  logic                  sig_in,
    temporal_pw_decoder_if.master out_if,
    output logic                  overrun
);

    localparam logic [TW-1:0] T_LAST = TW'(GAMMA_CYCLE_WIDTH - 1);
    localparam int RW = 2 * TW + 3;

    typedef struct packed {
        logic [TW-1:0] onset;
        logic [TW-1:0] width;
        logic          no_spike;
        logic          truncated;
        logic          multi;
    } result_t;

    pw_state_t     state, state_nx;
    logic [TW-1:0] t;  // t of the edge about to sample sig_in
    logic [TW-1:0] onset, onset_nx, width, width_nx;
    logic          multi, multi_nx;
    logic          close_early, close_last, commit;
    result_t       commit_data, res_q;

    always_comb begin
        state_nx = state;
        onset_nx = onset;
        width_nx = width;
        multi_nx = multi;
        case (state)
            WAIT_ON: if (sig_in) begin
                onset_nx = t;
                width_nx = TW'(1);
                state_nx = HIGH;
            end
            HIGH: begin
                if (sig_in) width_nx = width + 1'b1;
                else        state_nx = DONE;
            end
            DONE: if (sig_in) multi_nx = 1'b1;
            default: ;
        endcase

        // An early gamma_start edge is t=0 of the next cycle, so its sample is not measured.
        close_early = (state != IDLE) && gamma_start;
        close_last  = (state != IDLE) && !gamma_start && (t == T_LAST);
        commit      = close_early || close_last;
        if (close_early)
            commit_data = '{onset, width, state == WAIT_ON, state == HIGH, multi};
        else
            commit_data = '{onset_nx, width_nx, state_nx == WAIT_ON, state_nx == HIGH, multi_nx};
    end

    always_ff @(posedge aclk or negedge grst_n) begin
        if (!grst_n) begin
            state <= IDLE;
            t     <= '0;
            onset <= '0;
            width <= '0;
            multi <= 1'b0;
        end else if (gamma_start) begin
            state <= WAIT_ON;
            t     <= TW'(1);
            onset <= '0;
            width <= '0;
            multi <= 1'b0;
        end else if (close_last) begin
            state <= IDLE;
            t     <= '0;
            onset <= '0;
            width <= '0;
            multi <= 1'b0;
        end else if (state != IDLE) begin
            state <= state_nx;
            t     <= t + 1'b1;
            onset <= onset_nx;
            width <= width_nx;
            multi <= multi_nx;
        end
    end

    temporal_result_reg #(.W(RW)) u_result_reg (
        .aclk      (aclk),
        .rst_n     (grst_n),
        .load      (commit),
        .load_data (commit_data),
        .out_ready (out_if.out_ready),
        .out_valid (out_if.out_valid),
        .out_data  (res_q),
        .overrun   (overrun)
    );

    assign out_if.out_onset     = res_q.onset;
    assign out_if.out_width     = res_q.width;
    assign out_if.out_no_spike  = res_q.no_spike;
    assign out_if.out_truncated = res_q.truncated;
    assign out_if.out_multi     = res_q.multi;

endmodule

// File: tb/tb_temporal_pw_decoder.sv
// tb/tb_temporal_pw_decoder.sv - scoreboard bench for temporal_pw_decoder
module tb_temporal_pw_decoder;
    import temporal_pkg::*;

    localparam int G  = GAMMA_CYCLE_WIDTH_DEFAULT;
    localparam int TW = TW_DEFAULT;

    logic aclk = 1'b0;
    logic grst_n;
    logic gamma_start;
    logic sig_in;
    logic overrun;

    temporal_pw_decoder_if #(.TW(TW)) bus ();

    temporal_pw_decoder #(.GAMMA_CYCLE_WIDTH(G)) dut (
        .aclk        (aclk),
        .grst_n      (grst_n),
        .gamma_start (gamma_start),
        .sig_in      (sig_in),
        .out_if      (bus),
        .overrun     (overrun)
    );

    always #5 aclk = ~aclk;

    int         checks = 0;
    int         passes = 0;
    pw_result_t exp_q[$];
    logic       pre_close_valid;

    // Reference: measure the first run of ones among samples t=1..len-1.
    function automatic pw_result_t model(input logic [G-1:0] pat, input int len);
        pw_result_t r;
        int first;
        int w;
        r = '0;
        first = -1;
        w = 0;
        for (int i = 1; i < len; i++)
            if (pat[i] && first < 0) first = i;
        if (first < 0) begin
            r.no_spike = 1'b1;
            return r;
        end
        while (first + w < len && pat[first+w]) w++;
        r.onset     = TW'(first);
        r.width     = TW'(w);
        r.truncated = (first + w == len);
        for (int i = first + w; i < len; i++)
            if (pat[i]) r.multi = 1'b1;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic run_cycle(input logic [G-1:0] pat, input int len, input bit drop, input bit rdy_last);
        gamma_start = 1'b1;
        sig_in      = pat[0];
        @(posedge aclk);
        #1;
        gamma_start = 1'b0;
        for (int t = 1; t < len; t++) begin
            sig_in = pat[t];
            if (t == len - 1) begin
                pre_close_valid = bus.out_valid;
                if (rdy_last) bus.out_ready = 1'b1;
            end
            @(posedge aclk);
            #1;
        end
        sig_in = 1'b0;
        if (!drop) exp_q.push_back(model(pat, len));
    endtask

    function automatic logic [G-1:0] run_bits(input int lo, input int hi);
        logic [G-1:0] p;
        p = '0;
        for (int i = lo; i <= hi; i++) p[i] = 1'b1;
        return p;
    endfunction

    // Monitor: a handshake happens at the next posedge, so the front entry must match now.
    pw_result_t got_r, exp_r;
    always @(negedge aclk) begin
        if (grst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            got_r = '{bus.out_onset, bus.out_width, bus.out_no_spike, bus.out_truncated, bus.out_multi};
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL result: unexpected out_valid with onset=%0d width=%0d", got_r.onset, got_r.width);
            end else begin
                exp_r = exp_q.pop_front();
                if (got_r === exp_r) passes++;
                else $display("FAIL result: got onset=%0d width=%0d ns=%0b tr=%0b mu=%0b expected onset=%0d width=%0d ns=%0b tr=%0b mu=%0b",
                              got_r.onset, got_r.width, got_r.no_spike, got_r.truncated, got_r.multi,
                              exp_r.onset, exp_r.width, exp_r.no_spike, exp_r.truncated, exp_r.multi);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [G-1:0] pa;
        pw_result_t   ra;
        int           len, on, w;

        grst_n        = 1'b0;
        gamma_start   = 1'b0;
        sig_in        = 1'b0;
        bus.out_ready = 1'b1;
        idle(2);
        chk("reset_valid", 32'(bus.out_valid), 0);
        chk("reset_overrun", 32'(overrun), 0);
        grst_n = 1'b1;
        idle(2);

        // No spike, then a clean pulse with latency check.
        run_cycle('0, G, 0, 0);
        chk("nospike_valid", 32'(bus.out_valid), 1);
        chk("nospike_flag", 32'(bus.out_no_spike), 1);
        idle(2);
        run_cycle(run_bits(3, 10), G, 0, 0);
        chk("latency_pre_close", 32'(pre_close_valid), 0);
        chk("latency_post_close", 32'(bus.out_valid), 1);
        idle(2);
        chk("handshake_drains", 32'(bus.out_valid), 0);
        run_cycle(run_bits(2, 4) | run_bits(8, 9), G, 0, 0);
        run_cycle(run_bits(12, 15), G, 0, 0);
        run_cycle(run_bits(2, 3), 6, 0, 0);
        run_cycle(run_bits(0, 5), G, 0, 0);
        idle(3);

        // Overrun: two closes with ready low, then a same-edge replace.
        bus.out_ready = 1'b0;
        pa = run_bits(5, 7);
        ra = model(pa, G);
        run_cycle(pa, G, 0, 0);
        chk("hold_valid", 32'(bus.out_valid), 1);
        chk("no_overrun_yet", 32'(overrun), 0);
        run_cycle(run_bits(1, 2), G, 1, 0);
        chk("overrun_set", 32'(overrun), 1);
        chk("held_onset", 32'(bus.out_onset), 32'(ra.onset));
        chk("held_width", 32'(bus.out_width), 32'(ra.width));
        run_cycle(run_bits(9, 15), G, 0, 1);
        chk("replace_valid", 32'(bus.out_valid), 1);
        idle(3);
        chk("overrun_sticky", 32'(overrun), 1);

        // Asynchronous reset mid-pulse with a result held.
        bus.out_ready = 1'b0;
        run_cycle(run_bits(4, 4), G, 0, 0);
        gamma_start = 1'b1;
        @(posedge aclk);
        #1;
        gamma_start = 1'b0;
        for (int t = 1; t <= 5; t++) begin
            sig_in = (t >= 2);
            @(posedge aclk);
            #1;
        end
        #2;
        grst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.out_valid), 0);
        chk("arst_overrun", 32'(overrun), 0);
        chk("arst_onset", 32'(bus.out_onset), 0);
        chk("arst_width", 32'(bus.out_width), 0);
        chk("arst_flags", 32'({bus.out_no_spike, bus.out_truncated, bus.out_multi}), 0);
        exp_q.delete();
        @(posedge aclk);
        #1;
        grst_n        = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            sig_in = 1'($urandom);
            @(posedge aclk);
            #1;
        end
        sig_in = 1'b0;
        chk("post_reset_no_commit", 32'(bus.out_valid), 0);
        run_cycle(run_bits(6, 8), G, 0, 0);
        chk("post_reset_commit", 32'(bus.out_valid), 1);
        idle(2);

        // Randomized cycles, some closed early.
        for (int n = 0; n < 40; n++) begin
            case ($urandom % 4)
                0: pa = '0;
                1: begin
                    on = $urandom_range(1, G - 1);
                    w  = $urandom_range(1, G - on);
                    pa = run_bits(on, on + w - 1);
                end
                2: pa = G'($urandom) & G'($urandom);
                default: pa = G'($urandom);
            endcase
            pa[0] = 1'($urandom);
            len = (n == 39 || ($urandom % 10) < 7) ? G : $urandom_range(2, G - 1);
            run_cycle(pa, len, 0, 0);
        end
        idle(4);
        chk("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/temporal_pw_decoder.md
Name: temporal_pw_decoder

Overview:
Converts one pulse-width temporal-coded wire back into binary. It is the receive end of the race-logic pulse encoding used by the max/min primitives. Within each gamma cycle it measures two values on the first pulse: onset (arrival time) and width (duration). It then presents both, with status flags, on a valid/ready output register. It sits at the boundary between temporal-domain columns and the binary readout/host logic.

Parameters:
GAMMA_CYCLE_WIDTH, 16, aclk cycles per gamma cycle, including the start cycle (t = 0..GAMMA_CYCLE_WIDTH-1).
TW, $clog2(GAMMA_CYCLE_WIDTH), width of the onset and width fields.

Ports:
aclk  in  1  single clock; all sampling on posedge.
grst_n  in  1  asynchronous active-low reset.
gamma_start  in  1  synchronous pulse marking t=0 of a new gamma cycle.
sig_in  in  1  pulse-width coded input (level, active-high).
out_valid  out  1  result register holds an unconsumed result.
out_ready  in  1  consumer accepts the result when out_valid && out_ready at posedge.
out_onset  out  TW  t of the first posedge at which sig_in was sampled 1.
out_width  out  TW  number of consecutive samples of 1 starting at onset.
out_no_spike  out  1  no sample of 1 occurred in the cycle.
out_truncated  out  1  sig_in was still 1 at the cycle-closing sample.
out_multi  out  1  sig_in rose again after the first pulse ended.
overrun  out  1  sticky: a result was dropped because the register was full.

Behaviour:
- Reset (grst_n=0, asynchronous): FSM=IDLE, t=0, all outputs 0, out_valid=0, overrun=0. Reset mid-cycle discards the partial measurement.
- Local time t: set to 0 at the edge sampling gamma_start=1, then +1 per edge. sig_in sampled at the t=0 edge is ignored. Samples t=1..GAMMA_CYCLE_WIDTH-1 are measured.
- FSM states:
  - IDLE: wait for gamma_start → WAIT_ON.
  - WAIT_ON: sample 1 → onset=t, width=1, → HIGH.
  - HIGH: sample 1 → width+1. Sample 0 → DONE.
  - DONE: sample 1 → multi=1, and the measurement is unchanged.
- Cycle close: happens at the edge where t==GAMMA_CYCLE_WIDTH-1 (after processing that sample), or at an early gamma_start.
  - Close at t==GAMMA_CYCLE_WIDTH-1 → IDLE.
  - Early gamma_start closes the current cycle and starts the next one at t=0 in the same edge; the FSM goes to WAIT_ON.
  - Either way, the measurement is committed at that edge.
- Commit contents:
  - no_spike=1 if the FSM never left WAIT_ON; onset and width are then 0.
  - truncated=1 if the FSM is in HIGH at close.
  - Flags describe the committed cycle only.
- Output register and handshake: the commit is visible the cycle after the close edge (latency 1). Fields are stable while out_valid=1.
  - Commit with out_valid=0 → load, out_valid=1.
  - Commit with out_valid && out_ready at the same edge → old result consumed, new result loaded, out_valid stays 1.
  - Commit with out_valid && !out_ready → new result dropped, old one kept, overrun=1. overrun clears only on reset.
  - Handshake with no commit → out_valid=0 next cycle.
- gamma_start while in IDLE with no prior cycle: no commit, only a start.
- Max width is GAMMA_CYCLE_WIDTH-1 (onset=1, high through close), which fits in TW.

Decomposition:
- Shared package temporal_pkg:
  - FSM enum (IDLE, WAIT_ON, HIGH, DONE).
  - Packed result struct {onset, width, no_spike, truncated, multi}.
  - Default GAMMA_CYCLE_WIDTH constant, shared with encoders and testbenches.
- One natural sub-module: temporal_result_reg. It is a one-entry valid/ready holding register that carries the overrun logic, and it can be reused by the encoder side.

Test Plan (GAMMA_CYCLE_WIDTH=16):
1. gamma_start, sig_in=0 for the whole cycle → after close: out_valid=1, no_spike=1, onset=0, width=0, out_ready=1 consumes it.
2. gamma_start, sig_in=1 for t=3..10 → onset=3, width=8, no flags, valid one cycle after the t=15 edge.
3. sig_in=1 for t=2..4 and again for t=8..9 → onset=2, width=3, multi=1.
4. sig_in rises at t=12 and stays high through close → onset=12, width=4, truncated=1. A second gamma_start at t=6 of a cycle with a pulse at t=2..3 commits onset=2, width=2 early.
5. out_ready=0 across two cycle closes → first result held unchanged, overrun=1. Then out_ready=1 on the same edge as the third commit → third result loaded, out_valid stays 1.
6. Assert grst_n=0 asynchronously mid-pulse (t=5, HIGH) → all outputs 0 immediately. After release, no commit until the next gamma_start-delimited cycle completes.
